// File: rtl/uart_rx_ctrl_if.sv
// Byte streams around the receive controller: engine-to-controller drain and FIFO read side.
interface uart_rx_ctrl_if;
   logic       eng_valid;
   logic       eng_ready;
   logic [7:0] eng_data;
   logic       eng_busy;
   logic       rd_valid;
   logic       rd_ready;
   logic [7:0] rd_data;

   modport master (
      output eng_valid, eng_data, eng_busy, rd_ready,
      input  eng_ready, rd_valid, rd_data
   );

   modport slave (
      input  eng_valid, eng_data, eng_busy, rd_ready,
      output eng_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: x16 baud tick, engine drain into a FWFT FIFO, character timeout,
// sticky overrun and a registered level interrupt.
module uart_rx_ctrl #(
   parameter int unsigned  DIV_W         = 16,
   parameter int unsigned  DEPTH         = 8,
   parameter int unsigned  TIMEOUT_TICKS = 640,
   localparam int unsigned AW            = $clog2(DEPTH),
   localparam int unsigned LW            = AW + 1,
   localparam int unsigned TW            = $clog2(TIMEOUT_TICKS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_enable,
   input  logic [DIV_W-1:0] cfg_divisor,
   input  logic             cfg_irq_en,
   input  logic [LW-1:0]    cfg_irq_thresh,
   input  logic             cfg_flush,
   input  logic             overrun_clr,
   output logic             baud_x16_tick,
   uart_rx_ctrl_if.slave    bus,
   output logic [LW-1:0]    fifo_level,
   output logic             overrun,
   output logic             timeout,
   output logic             rx_on,
   output logic             irq
);

   typedef enum logic [1:0] {StOff, StOn, StStop} state_e;

   state_e state_q, state_d;

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             baud_run;

   logic [7:0]    mem_q [DEPTH];
   logic [LW-1:0] wr_ptr_q, rd_ptr_q;
   logic          empty, full;
   logic          push_req, push_ok, pop, drop;

   logic          overrun_q;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          tcnt_clr;
   logic          irq_q;

   // ---------------- Control FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StOff;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StOff: begin
            if (cfg_enable) state_d = StOn;
         end
         StOn: begin
            if (!cfg_enable) state_d = bus.eng_busy ? StStop : StOff;
         end
         StStop: begin
            if (cfg_enable) begin
               state_d = StOn;
            end else if (!bus.eng_busy) begin
               state_d = StOff;
            end
         end
         default: state_d = StOff;
      endcase
   end

   assign rx_on         = (state_q != StOff);
   assign bus.eng_ready = rx_on;

   // ---------------- Baud counter ----------------
   assign baud_run = rx_on && (cfg_divisor != '0);

   // >= rather than == so a shrunk divisor cannot strand the counter above the wrap point
   always_comb begin
      cnt_d  = '0;
      tick_d = 1'b0;
      if (baud_run) begin
         if (cnt_q >= (cfg_divisor - DIV_W'(1))) begin
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign baud_x16_tick = tick_q;

   // ---------------- FIFO ----------------
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign push_req = bus.eng_valid && bus.eng_ready;
   assign pop      = !empty && bus.rd_ready;
   assign push_ok  = push_req && (!full || pop) && !cfg_flush;
   assign drop     = push_req && full && !pop && !cfg_flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (cfg_flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + LW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= bus.eng_data;
      end
   end

   assign bus.rd_valid = !empty;
   assign bus.rd_data  = mem_q[rd_ptr_q[AW-1:0]];
   assign fifo_level   = wr_ptr_q - rd_ptr_q;

   // ---------------- Overrun ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (drop) begin
         overrun_q <= 1'b1;
      end else if (overrun_clr) begin
         overrun_q <= 1'b0;
      end
   end

   assign overrun = overrun_q;

   // ---------------- Character timeout ----------------
   assign tcnt_clr = push_req || pop || bus.eng_busy || empty || cfg_flush || !rx_on;

   always_comb begin
      tcnt_d = tcnt_q;
      if (tcnt_clr) begin
         tcnt_d = '0;
      end else if (tick_q && (tcnt_q != TW'(TIMEOUT_TICKS))) begin
         tcnt_d = tcnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end

   assign timeout = (tcnt_q == TW'(TIMEOUT_TICKS));

   // ---------------- Interrupt ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= cfg_irq_en && (((cfg_irq_thresh != '0) && (fifo_level >= cfg_irq_thresh))
                                 || timeout || overrun_q);
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed feature scenarios plus a randomized run
// against a queue-based reference model.
module tb_uart_rx_ctrl;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_enable;
   logic [15:0] cfg_divisor;
   logic        cfg_irq_en;
   logic [3:0]  cfg_irq_thresh;
   logic        cfg_flush;
   logic        overrun_clr;
   logic        baud_x16_tick;
   logic [3:0]  fifo_level;
   logic        overrun;
   logic        timeout;
   logic        rx_on;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [7:0] mq[$];
   bit         m_ovr;
   bit         m_irq;
   int         m_mode;   // 0 off, 1 on, 2 stopping

   uart_rx_ctrl_if bus ();

   uart_rx_ctrl #(
      .DIV_W         (16),
      .DEPTH         (DEPTH),
      .TIMEOUT_TICKS (640)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cfg_enable     (cfg_enable),
      .cfg_divisor    (cfg_divisor),
      .cfg_irq_en     (cfg_irq_en),
      .cfg_irq_thresh (cfg_irq_thresh),
      .cfg_flush      (cfg_flush),
      .overrun_clr    (overrun_clr),
      .baud_x16_tick  (baud_x16_tick),
      .bus            (bus),
      .fifo_level     (fifo_level),
      .overrun        (overrun),
      .timeout        (timeout),
      .rx_on          (rx_on),
      .irq            (irq)
   );

   always #5 clk = ~clk;

   // Advance one clock, updating the model from the inputs seen at that edge.
   task automatic cycle();
      int   n;
      bit   push, pop, drop, irq_n, rst_seen;
      int   mode_n;
      n        = mq.size();
      rst_seen = !rst_n;
      irq_n    = cfg_irq_en && (((cfg_irq_thresh != 0) && (n >= int'(cfg_irq_thresh))) || m_ovr);
      push     = bus.eng_valid && (m_mode != 0);
      pop      = (n > 0) && bus.rd_ready;
      drop     = push && (n == DEPTH) && !pop && !cfg_flush;
      mode_n   = m_mode;
      if (m_mode == 0 && cfg_enable) mode_n = 1;
      else if (m_mode == 1 && !cfg_enable) mode_n = bus.eng_busy ? 2 : 0;
      else if (m_mode == 2) mode_n = cfg_enable ? 1 : (bus.eng_busy ? 2 : 0);
      @(posedge clk);
      if (rst_seen) begin
         mq.delete();
         m_ovr  = 0;
         m_irq  = 0;
         m_mode = 0;
      end else begin
         m_irq = irq_n;
         if (cfg_flush) begin
            mq.delete();
         end else begin
            if (pop) void'(mq.pop_front());
            if (push && !drop) mq.push_back(bus.eng_data);
         end
         if (drop) m_ovr = 1;
         else if (overrun_clr) m_ovr = 0;
         m_mode = mode_n;
      end
      #1;
   endtask

   task automatic idle_inputs();
      cfg_enable     = 0;
      cfg_divisor    = 0;
      cfg_irq_en     = 0;
      cfg_irq_thresh = 0;
      cfg_flush      = 0;
      overrun_clr    = 0;
      bus.eng_valid  = 0;
      bus.eng_data   = 0;
      bus.eng_busy   = 0;
      bus.rd_ready   = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      cycle();
      rst_n = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      cycle();
      cycle();
      rst_n = 1;
      checks++; if (baud_x16_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b, expected 0", baud_x16_tick); end
      checks++; if (bus.eng_ready !== 1'b0) begin failures++; $display("FAIL reset_eng_ready: got %b, expected 0", bus.eng_ready); end
      checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b, expected 0", bus.rd_valid); end
      checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data: got %h, expected 00", bus.rd_data); end
      checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL reset_level: got %0d, expected 0", fifo_level); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b, expected 0", timeout); end
      checks++; if (rx_on !== 1'b0) begin failures++; $display("FAIL reset_rx_on: got %b, expected 0", rx_on); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b, expected 0", irq); end
   endtask

   task automatic test_baud();
      do_reset();
      cfg_divisor = 4;
      cfg_enable  = 1;
      cycle();
      checks++; if (rx_on !== 1'b1) begin failures++; $display("FAIL baud_rx_on: got %b, expected 1", rx_on); end
      for (int k = 1; k <= 16; k++) begin
         cycle();
         checks++;
         if (baud_x16_tick !== ((k % 4) == 0)) begin
            failures++; $display("FAIL baud_div4 k=%0d: got %b, expected %b", k, baud_x16_tick, (k % 4) == 0);
         end
      end
      cfg_divisor = 0;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         checks++;
         if (baud_x16_tick !== 1'b0) begin failures++; $display("FAIL baud_div0 k=%0d: got %b, expected 0", k, baud_x16_tick); end
      end
      cfg_divisor = 4;
      for (int k = 1; k <= 16; k++) begin
         cycle();
         checks++;
         if (baud_x16_tick !== ((k % 4) == 0)) begin
            failures++; $display("FAIL baud_div0to4 k=%0d: got %b, expected %b", k, baud_x16_tick, (k % 4) == 0);
         end
      end
      cfg_divisor = 1;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         checks++;
         if (baud_x16_tick !== 1'b1) begin failures++; $display("FAIL baud_div1 k=%0d: got %b, expected 1", k, baud_x16_tick); end
      end
      cfg_divisor = 0;
   endtask

   task automatic test_fifo_order();
      logic [7:0] bytes [3];
      bytes[0] = 8'h55; bytes[1] = 8'hA3; bytes[2] = 8'h0F;
      do_reset();
      cfg_enable = 1;
      cycle();
      for (int i = 0; i < 3; i++) begin
         bus.eng_valid = 1;
         bus.eng_data  = bytes[i];
         cycle();
      end
      bus.eng_valid = 0;
      checks++; if (fifo_level !== 4'd3) begin failures++; $display("FAIL order_level: got %0d, expected 3", fifo_level); end
      checks++; if (bus.rd_data !== 8'h55) begin failures++; $display("FAIL order_head: got %h, expected 55", bus.rd_data); end
      bus.rd_ready = 1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== bytes[i]) begin
            failures++; $display("FAIL order_read%0d: got v=%b d=%h, expected v=1 d=%h", i, bus.rd_valid, bus.rd_data, bytes[i]);
         end
         cycle();
      end
      bus.rd_ready = 0;
      checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL order_empty: got %b, expected 0", bus.rd_valid); end
   endtask

   task automatic test_overrun();
      logic [7:0] exp[$];
      logic [7:0] d;
      do_reset();
      cfg_enable = 1;
      cfg_irq_en = 1;
      cycle();
      for (int i = 0; i < 9; i++) begin
         d = 8'($urandom);
         bus.eng_valid = 1;
         bus.eng_data  = d;
         if (i < 8) exp.push_back(d);
         cycle();
      end
      bus.eng_valid = 0;
      checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL ovr_level: got %0d, expected 8", fifo_level); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b, expected 1", overrun); end
      checks++; if (bus.rd_data !== exp[0]) begin failures++; $display("FAIL ovr_head: got %h, expected %h", bus.rd_data, exp[0]); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ovr_irq_early: got %b, expected 0", irq); end
      cycle();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ovr_irq: got %b, expected 1", irq); end
      d = 8'($urandom);
      bus.eng_valid = 1; bus.eng_data = d; bus.rd_ready = 1;
      cycle();
      bus.eng_valid = 0; bus.rd_ready = 0;
      void'(exp.pop_front());
      exp.push_back(d);
      checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL ovr_pushpop_level: got %0d, expected 8", fifo_level); end
      checks++; if (bus.rd_data !== exp[0]) begin failures++; $display("FAIL ovr_pushpop_head: got %h, expected %h", bus.rd_data, exp[0]); end
      overrun_clr = 1;
      cycle();
      overrun_clr = 0;
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b, expected 0", overrun); end
      overrun_clr = 1; bus.eng_valid = 1; bus.eng_data = 8'($urandom);
      cycle();
      overrun_clr = 0; bus.eng_valid = 0;
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins: got %b, expected 1", overrun); end
      bus.rd_ready = 1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (bus.rd_data !== exp[i]) begin failures++; $display("FAIL ovr_drain%0d: got %h, expected %h", i, bus.rd_data, exp[i]); end
         cycle();
      end
      bus.rd_ready = 0;
      checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL ovr_drained: got %b, expected 0", bus.rd_valid); end
   endtask

   task automatic test_timeout();
      do_reset();
      cfg_divisor = 1;
      cfg_enable  = 1;
      cfg_irq_en  = 1;
      repeat (4) cycle();
      bus.eng_valid = 1; bus.eng_data = 8'h11;
      cycle();
      bus.eng_valid = 0;
      repeat (639) cycle();
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_early: got %b, expected 0", timeout); end
      cycle();
      checks++; if (timeout !== 1'b1 || irq !== 1'b0) begin failures++; $display("FAIL to_rise: got to=%b irq=%b, expected to=1 irq=0", timeout, irq); end
      cycle();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL to_irq: got %b, expected 1", irq); end
      bus.rd_ready = 1;
      cycle();
      bus.rd_ready = 0;
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_pop_clear: got %b, expected 0", timeout); end
      cycle();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL to_irq_clear: got %b, expected 0", irq); end
      bus.eng_valid = 1; bus.eng_data = 8'h22;
      cycle();
      bus.eng_valid = 0;
      repeat (638) cycle();
      bus.eng_valid = 1; bus.eng_data = 8'h33;
      cycle();
      bus.eng_valid = 0;
      cycle();
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_restart: got %b, expected 0", timeout); end
      repeat (638) cycle();
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_restart_early: got %b, expected 0", timeout); end
      cycle();
      checks++; if (timeout !== 1'b1 || fifo_level !== 4'd2) begin
         failures++; $display("FAIL to_restart_rise: got to=%b lvl=%0d, expected to=1 lvl=2", timeout, fifo_level);
      end
      bus.rd_ready = 1;
      cycle();
      bus.rd_ready = 0;
      checks++; if (timeout !== 1'b0 || fifo_level !== 4'd1) begin
         failures++; $display("FAIL to_pop2: got to=%b lvl=%0d, expected to=0 lvl=1", timeout, fifo_level);
      end
   endtask

   task automatic test_stop();
      int n, last, gap_bad;
      do_reset();
      cfg_divisor = 2;
      cfg_enable  = 1;
      repeat (3) cycle();
      bus.eng_busy = 1;
      cfg_enable   = 0;
      cycle();
      checks++; if (rx_on !== 1'b1 || bus.eng_ready !== 1'b1) begin
         failures++; $display("FAIL stop_enter: got rx_on=%b rdy=%b, expected 1 1", rx_on, bus.eng_ready);
      end
      n = 0;
      repeat (8) begin cycle(); n += int'(baud_x16_tick); end
      checks++; if (n != 4) begin failures++; $display("FAIL stop_ticks: got %0d, expected 4", n); end
      bus.eng_valid = 1; bus.eng_data = 8'h7E;
      cycle();
      bus.eng_valid = 0;
      checks++; if (fifo_level !== 4'd1 || bus.rd_data !== 8'h7E) begin
         failures++; $display("FAIL stop_capture: got lvl=%0d d=%h, expected lvl=1 d=7e", fifo_level, bus.rd_data);
      end
      bus.eng_busy = 0;
      cycle();
      checks++; if (rx_on !== 1'b0 || bus.eng_ready !== 1'b0) begin
         failures++; $display("FAIL stop_off: got rx_on=%b rdy=%b, expected 0 0", rx_on, bus.eng_ready);
      end
      cycle();
      n = 0;
      repeat (4) begin cycle(); n += int'(baud_x16_tick); end
      checks++; if (n != 0) begin failures++; $display("FAIL stop_no_ticks: got %0d, expected 0", n); end
      cfg_enable   = 1;
      bus.eng_busy = 1;
      repeat (3) cycle();
      cfg_enable = 0;
      cycle();
      checks++; if (rx_on !== 1'b1) begin failures++; $display("FAIL stop_reenter: got %b, expected 1", rx_on); end
      n = 0; last = -1; gap_bad = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 3) cfg_enable = 1;
         cycle();
         if (baud_x16_tick === 1'b1) begin
            if (last >= 0 && (k - last) != 2) gap_bad++;
            last = k;
            n++;
         end
      end
      checks++; if (n != 5 || gap_bad != 0) begin
         failures++; $display("FAIL stop_resume_ticks: got n=%0d gaps_bad=%0d, expected n=5 gaps_bad=0", n, gap_bad);
      end
      bus.eng_busy = 0;
      cycle();
      checks++; if (rx_on !== 1'b1) begin failures++; $display("FAIL stop_resumed_on: got %b, expected 1", rx_on); end
   endtask

   task automatic test_flush_and_reset();
      do_reset();
      cfg_enable = 1;
      cycle();
      for (int i = 0; i < 9; i++) begin
         bus.eng_valid = 1; bus.eng_data = 8'($urandom);
         cycle();
      end
      bus.eng_valid = 0;
      bus.rd_ready  = 1;
      repeat (5) cycle();
      bus.rd_ready = 0;
      checks++; if (fifo_level !== 4'd3 || overrun !== 1'b1) begin
         failures++; $display("FAIL flush_setup: got lvl=%0d ovr=%b, expected lvl=3 ovr=1", fifo_level, overrun);
      end
      cfg_flush = 1; bus.eng_valid = 1; bus.eng_data = 8'hAA;
      cycle();
      cfg_flush = 0; bus.eng_valid = 0;
      checks++; if (fifo_level !== 4'd0 || bus.rd_valid !== 1'b0 || overrun !== 1'b1) begin
         failures++; $display("FAIL flush: got lvl=%0d v=%b ovr=%b, expected lvl=0 v=0 ovr=1", fifo_level, bus.rd_valid, overrun);
      end
      cycle();
      checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL flush_discard: got %0d, expected 0", fifo_level); end
      bus.eng_valid = 1; bus.eng_data = 8'h3C; cycle();
      bus.eng_data  = 8'hC3; cycle();
      bus.eng_valid = 0;
      checks++; if (fifo_level !== 4'd2 || bus.rd_data !== 8'h3C) begin
         failures++; $display("FAIL flush_refill: got lvl=%0d d=%h, expected lvl=2 d=3c", fifo_level, bus.rd_data);
      end
      cfg_divisor = 1; cfg_irq_en = 1; cfg_irq_thresh = 1;
      repeat (2) cycle();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mid_pre_irq: got %b, expected 1", irq); end
      rst_n = 0; bus.eng_valid = 1; bus.eng_data = 8'h99; bus.rd_ready = 1;
      cycle();
      rst_n = 1; bus.eng_valid = 0; bus.rd_ready = 0;
      checks++; if (baud_x16_tick !== 1'b0 || bus.eng_ready !== 1'b0 || bus.rd_valid !== 1'b0 ||
                    bus.rd_data !== 8'h00 || fifo_level !== 4'd0 || overrun !== 1'b0 ||
                    timeout !== 1'b0 || rx_on !== 1'b0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: got tick=%b rdy=%b v=%b d=%h lvl=%0d ovr=%b to=%b on=%b irq=%b, expected all zero",
                  baud_x16_tick, bus.eng_ready, bus.rd_valid, bus.rd_data, fifo_level, overrun,
                  timeout, rx_on, irq);
      end
   endtask

   task automatic test_random();
      do_reset();
      cfg_irq_en = 1;
      for (int c = 0; c < 400; c++) begin
         cfg_enable    = ($urandom_range(0, 9) != 0);
         bus.eng_busy  = $urandom_range(0, 1) == 1;
         bus.eng_valid = ($urandom_range(0, 9) < 6);
         bus.eng_data  = 8'($urandom);
         bus.rd_ready  = ($urandom_range(0, 9) < 4);
         cfg_flush     = ($urandom_range(0, 39) == 0);
         overrun_clr   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 15) == 0) cfg_irq_thresh = 4'($urandom_range(0, 8));
         cycle();
         checks++;
         if (int'(fifo_level) != mq.size() || bus.rd_valid !== (mq.size() > 0)) begin
            failures++; $display("FAIL rnd_level c=%0d: got lvl=%0d v=%b, expected lvl=%0d", c, fifo_level, bus.rd_valid, mq.size());
         end
         if (mq.size() > 0) begin
            checks++;
            if (bus.rd_data !== mq[0]) begin failures++; $display("FAIL rnd_data c=%0d: got %h, expected %h", c, bus.rd_data, mq[0]); end
         end
         checks++;
         if (overrun !== m_ovr || irq !== m_irq) begin
            failures++; $display("FAIL rnd_flags c=%0d: got ovr=%b irq=%b, expected ovr=%b irq=%b", c, overrun, irq, m_ovr, m_irq);
         end
         checks++;
         if (rx_on !== (m_mode != 0) || bus.eng_ready !== (m_mode != 0)) begin
            failures++; $display("FAIL rnd_on c=%0d: got on=%b rdy=%b, expected %b", c, rx_on, bus.eng_ready, m_mode != 0);
         end
      end
      idle_inputs();
   endtask

   initial begin
      rst_n = 0;
      idle_inputs();
      test_reset();
      test_baud();
      test_fifo_order();
      test_overrun();
      test_timeout();
      test_stop();
      test_flush_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Controller that sequences the UART receive path. It generates the 16x-baud tick from a programmable divisor and drains received bytes from the RX engine's valid/ready stream into an internal FIFO. It also detects a character timeout, tracks overrun, and raises a level interrupt. The block sits between the RX engine and the MMIO register block: MMIO drives `cfg_*` and reads the FIFO through the `rd_*` stream.

## Interface
- `DIV_W`, 16: width of the baud divisor.
- `DEPTH`, 8: FIFO depth, in entries; must be a power of 2 and at least 2.
- `TIMEOUT_TICKS`, 640: idle x16 ticks (4 characters × 10 bits × 16) before a timeout is flagged.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_enable`  in  1  receive enable (level).
- `cfg_divisor`  in  DIV_W  clocks per x16 tick; 0 means no ticks.
- `cfg_irq_en`  in  1  interrupt enable.
- `cfg_irq_thresh`  in  $clog2(DEPTH)+1  FIFO level threshold; 0 disables the threshold source.
- `cfg_flush`  in  1  one-cycle pulse that empties the FIFO.
- `overrun_clr`  in  1  one-cycle pulse that clears `overrun`.
- `baud_x16_tick`  out  1  one-cycle pulse to the RX engine.
- `eng_valid`  in  1  RX engine byte valid.
- `eng_ready`  out  1  controller accepts the engine byte.
- `eng_data`  in  8  RX engine byte.
- `eng_busy`  in  1  RX engine not idle.
- `rd_valid`  out  1  FIFO not empty.
- `rd_ready`  in  1  consumer pops the head entry.
- `rd_data`  out  8  FIFO head (first-word fall-through).
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.
- `overrun`  out  1  sticky: a byte was dropped.
- `timeout`  out  1  character timeout pending.
- `rx_on`  out  1  state != S_OFF.
- `irq`  out  1  registered interrupt.

## Operation
- **Control FSM.**
  - `S_OFF` → `S_ON` when `cfg_enable` is high.
  - `S_ON` → `S_OFF` when `cfg_enable` is low and `eng_busy` is 0.
  - `S_ON` → `S_STOP` when `cfg_enable` is low and `eng_busy` is 1.
  - `S_STOP` → `S_ON` when `cfg_enable` is high; otherwise → `S_OFF` when `eng_busy` is 0.
  - `S_STOP` keeps ticks and `eng_ready` running so an in-flight frame completes and is captured.
- **Baud counter** (DIV_W bits).
  - Runs in `S_ON` and `S_STOP`; held at 0 in `S_OFF`, and also held at 0 when `cfg_divisor` == 0.
  - When `cnt >= cfg_divisor-1`: pulse `baud_x16_tick` and set `cnt` to 0; otherwise increment `cnt`.
  - The `>=` compare makes a shrinking divisor take effect within one tick period. `cfg_divisor` == 1 gives a tick every cycle.
- **Engine drain.** `eng_ready` = (state != `S_OFF`). A push is `eng_valid && eng_ready`.
  - A push while the FIFO is full and there is no pop in the same cycle drops the byte and sets `overrun`.
  - A push while full with a pop in the same cycle is accepted; level stays at DEPTH.
- **FIFO.**
  - Read and write pointers are $clog2(DEPTH)+1 bits. Empty = pointers equal; full = indices equal and MSBs differ.
  - A pop is `rd_valid && rd_ready`.
  - `rd_data` is the entry at the read index, read combinationally from the registered array.
  - Pop on empty is impossible because `rd_valid` = 0.
- **Flush.** `cfg_flush` zeroes both pointers and clears `timeout` and the timeout counter.
  - A push or pop in the same cycle is discarded; flush wins.
  - `overrun` is unaffected.
- **Overrun.** A set and `overrun_clr` in the same cycle leaves `overrun` = 1; set wins.
- **Timeout counter** ($clog2(TIMEOUT_TICKS+1) bits).
  - Cleared on a push, a pop, `eng_busy` = 1, FIFO empty, flush, or `S_OFF`.
  - Otherwise it increments on `baud_x16_tick` and saturates at TIMEOUT_TICKS.
  - `timeout` = 1 when the count equals TIMEOUT_TICKS, so it drops automatically on a pop or flush.
- **Interrupt.** The `irq` register is loaded with `cfg_irq_en && ((cfg_irq_thresh != 0 && fifo_level >= cfg_irq_thresh) || timeout || overrun)`.

## Timing
- **Reset** (`rst_n` low at a clock edge): state `S_OFF`, baud count 0, pointers 0, timeout counter 0.
  - Outputs after reset: `baud_x16_tick`=0, `eng_ready`=0, `rd_valid`=0, `rd_data`=8'h00 (array cleared), `fifo_level`=0, `overrun`=0, `timeout`=0, `rx_on`=0, `irq`=0.
  - Reset mid-frame drops the FIFO contents and the FSM state immediately.
- **Tick timing.** After entering `S_ON`, the first tick appears `cfg_divisor` cycles later; the period is exactly `cfg_divisor` cycles.
- **Push to read.** A push at edge N gives `rd_valid`=1 and an updated `fifo_level` after edge N, and `irq` after edge N+1.
- **Pop.** A pop at edge N advances `rd_data` after edge N.
- **Enable and disable.** `eng_ready` follows the state register, so there is one cycle of latency from `cfg_enable`.

## Test plan
- Divisor 4, enabled → `baud_x16_tick` pulses every 4th cycle; then divisor 0 → no ticks, counter stays 0; divisor 1 → tick every cycle.
- Push 0x55, 0xA3, 0x0F with `rd_ready`=0 → `fifo_level`=3, `rd_data`=0x55. Then `rd_ready`=1 for 3 cycles → reads 0x55, 0xA3, 0x0F, `rd_valid` drops.
- DEPTH=8: push 9 bytes, no pops → level 8, 9th byte dropped, `overrun`=1, `irq`=1 with `cfg_irq_en`. Push and pop together while full → accepted, level 8. `overrun_clr` with a simultaneous drop → `overrun` stays 1.
- One byte in the FIFO, `eng_busy`=0, divisor 1 → `timeout` rises after 640 ticks and `irq` follows one cycle later. A pop clears both; a push at tick 639 restarts the count.
- Drop `cfg_enable` mid-frame (`eng_busy`=1) → state `S_STOP`, ticks continue, byte 0x7E captured, `S_OFF` once busy=0, `eng_ready`=0. Re-enable during `S_STOP` → `S_ON` with no tick gap.
- 3 entries, `cfg_flush` in the same cycle as a push → level 0, byte discarded, `overrun` unchanged. Reset asserted mid-stream → all outputs at reset values on the next edge.
